// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Round-robin arbiter and command sequencer for one single-port RAM shared by
// two clients. One command is in flight at a time: the winning command is
// latched in IDLE, driven onto the RAM pins for one ISSUE cycle, then (for
// reads) waited on for RD_LAT cycles before the data is captured. Completion
// is signalled with a one-cycle done pulse to the issuing client.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req0/we0/addr0/wdata0          client 0 command (held until gnt0)
//   gnt0, done0, rdata0            client 0 accept pulse, completion pulse, read data
//   req1/we1/addr1/wdata1          client 1 command (held until gnt1)
//   gnt1, done1, rdata1            client 1 accept pulse, completion pulse, read data
//   ram_addr, ram_in, ram_out      RAM address, write data, read data
//   ram_r, ram_w, ram_en           RAM read strobe, write strobe, enable
// -----------------------------------------------------------------------------
module ram_arbiter #(
   parameter int AW     = 8,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          done0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          done1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_in,
   input  logic [DW-1:0] ram_out,
   output logic          ram_r,
   output logic          ram_w,
   output logic          ram_en
);

   // Counter only ever holds RD_LAT-1, so clog2(RD_LAT) bits suffice.
   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last_q, last_d;     // client served most recently
   logic            id_q, id_d;         // client owning the command in flight
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata0_q, rdata0_d;
   logic [DW-1:0]   rdata1_q, rdata1_d;
   logic            done0_q, done0_d;
   logic            done1_q, done1_d;
   logic            ram_en_q, ram_en_d;
   logic            ram_r_q, ram_r_d;
   logic            ram_w_q, ram_w_d;
   logic            grant_s;
   logic            pick_s;             // winning client when grant_s is set

   // Next-state, arbitration and command-latch logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      id_d     = id_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      ram_en_d = 1'b0;
      ram_r_d  = 1'b0;
      ram_w_d  = 1'b0;
      grant_s  = 1'b0;
      pick_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // On a tie the client that was not served last wins.
            if (req0 && req1) begin
               grant_s = 1'b1;
               pick_s  = ~last_q;
            end else if (req0) begin
               grant_s = 1'b1;
               pick_s  = 1'b0;
            end else if (req1) begin
               grant_s = 1'b1;
               pick_s  = 1'b1;
            end else begin
               grant_s = 1'b0;
               pick_s  = 1'b0;
            end
            if (grant_s) begin
               id_d     = pick_s;
               last_d   = pick_s;
               we_d     = pick_s ? we1 : we0;
               addr_d   = pick_s ? addr1 : addr0;
               wdata_d  = pick_s ? wdata1 : wdata0;
               state_d  = S_ISSUE;
               // RAM strobes are registered so they are high exactly in ISSUE.
               ram_en_d = 1'b1;
               ram_w_d  = we_d;
               ram_r_d  = ~we_d;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d = S_RESP;
               done0_d = ~id_q;
               done1_d = id_q;
            end else begin
               cnt_d   = CW'(RD_LAT - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // Only the owning client's read data register is updated.
               if (id_q) begin
                  rdata1_d = ram_out;
               end else begin
                  rdata0_d = ram_out;
               end
               state_d = S_RESP;
               done0_d = ~id_q;
               done1_d = id_q;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any command in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         ram_en_q <= 1'b0;
         ram_r_q  <= 1'b0;
         ram_w_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         id_q     <= id_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         ram_en_q <= ram_en_d;
         ram_r_q  <= ram_r_d;
         ram_w_q  <= ram_w_d;
      end
   end

   // The grant pulse acknowledges the request in the same cycle, so it is
   // decoded from the inputs; it is masked while reset is asserted.
   assign gnt0     = grant_s & ~pick_s & ~rst;
   assign gnt1     = grant_s & pick_s & ~rst;
   assign done0    = done0_q;
   assign done1    = done1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign ram_addr = addr_q;
   assign ram_in   = wdata_q;
   assign ram_en   = ram_en_q;
   assign ram_r    = ram_r_q;
   assign ram_w    = ram_w_q;

endmodule
